// File: rtl/spi_slv.sv
// SPI mode-0 slave for the DSO command link: oversampled pins, 16-bit
// command capture with sticky ready flag, and a buffered MISO response.
module spi_slv #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             wrt,
    input  logic             clr_cmd_rdy,
    output logic [WIDTH-1:0] cmd,
    output logic             cmd_rdy,
    output logic             frm_err
);

    typedef enum logic [1:0] {
        WAIT_HI,
        IDLE,
        SHIFT
    } state_t;

    localparam logic [4:0] CNT_FULL = 5'(WIDTH);
    localparam logic [4:0] CNT_MAX  = 5'(WIDTH + 1);

    state_t state_q, state_d;

    logic [2:0] ss_sync_q, ss_sync_d;
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [2:0] mosi_sync_q, mosi_sync_d;

    logic [1:0]       wait_cnt_q, wait_cnt_d;
    logic [WIDTH-1:0] tx_buf_q, tx_buf_d;
    logic [WIDTH-1:0] tx_shft_q, tx_shft_d;
    logic [WIDTH-1:0] rx_shft_q, rx_shft_d;
    logic [4:0]       bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] cmd_q, cmd_d;
    logic             cmd_rdy_q, cmd_rdy_d;
    logic             frm_err_q, frm_err_d;

    logic ss_fall, ss_rise, sclk_rise, sclk_fall;

    assign ss_sync_d   = {ss_sync_q[1:0], SS_n};
    assign sclk_sync_d = {sclk_sync_q[1:0], SCLK};
    assign mosi_sync_d = {mosi_sync_q[1:0], MOSI};

    assign ss_fall   = ~ss_sync_q[1] &  ss_sync_q[2];
    assign ss_rise   =  ss_sync_q[1] & ~ss_sync_q[2];
    assign sclk_rise =  sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] &  sclk_sync_q[2];

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_buf_d   = tx_buf_q;
        tx_shft_d  = tx_shft_q;
        rx_shft_d  = rx_shft_q;
        bit_cnt_d  = bit_cnt_q;
        cmd_d      = cmd_q;
        cmd_rdy_d  = cmd_rdy_q;
        frm_err_d  = 1'b0;

        if (wrt) tx_buf_d = tx_data;
        if (clr_cmd_rdy) cmd_rdy_d = 1'b0;

        unique case (state_q)
            // Let the synchronizer flush its reset value before trusting SS_n.
            WAIT_HI: begin
                if (wait_cnt_q != 2'd3) begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end else if (ss_sync_q[1] && ss_sync_q[2]) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    tx_shft_d = wrt ? tx_data : tx_buf_q;
                    bit_cnt_d = '0;
                    rx_shft_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise) begin
                    rx_shft_d = {rx_shft_q[WIDTH-2:0], mosi_sync_q[2]};
                    if (bit_cnt_q != CNT_MAX) bit_cnt_d = bit_cnt_q + 5'd1;
                end
                if (sclk_fall) tx_shft_d = {tx_shft_q[WIDTH-2:0], 1'b0};
                if (ss_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        cmd_d     = rx_shft_q;
                        cmd_rdy_d = 1'b1;
                    end else begin
                        frm_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = WAIT_HI;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_HI;
            ss_sync_q   <= 3'b111;
            sclk_sync_q <= 3'b000;
            mosi_sync_q <= 3'b000;
            wait_cnt_q  <= '0;
            tx_buf_q    <= '0;
            tx_shft_q   <= '0;
            rx_shft_q   <= '0;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            cmd_rdy_q   <= 1'b0;
            frm_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_sync_q   <= ss_sync_d;
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_buf_q    <= tx_buf_d;
            tx_shft_q   <= tx_shft_d;
            rx_shft_q   <= rx_shft_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            cmd_rdy_q   <= cmd_rdy_d;
            frm_err_q   <= frm_err_d;
        end
    end

    assign MISO    = tx_shft_q[WIDTH-1];
    assign cmd     = cmd_q;
    assign cmd_rdy = cmd_rdy_q;
    assign frm_err = frm_err_q;

endmodule

// File: tb/tb_spi_slv.sv
// Directed bench for spi_slv: acts as a mode-0 master at SCLK = clk/32
// and checks command capture, response shifting and error handling.
module tb_spi_slv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b0;
    logic        MOSI = 1'b0;
    logic        MISO;
    logic [15:0] tx_data = '0;
    logic        wrt = 1'b0;
    logic        clr_cmd_rdy = 1'b0;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        frm_err;

    int nvec = 0;
    int nerr = 0;
    int err_cnt = 0;
    logic [15:0] cap;
    logic        m;

    spi_slv dut (
        .clk(clk),
        .rst_n(rst_n),
        .SS_n(SS_n),
        .SCLK(SCLK),
        .MOSI(MOSI),
        .MISO(MISO),
        .tx_data(tx_data),
        .wrt(wrt),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd(cmd),
        .cmd_rdy(cmd_rdy),
        .frm_err(frm_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frm_err === 1'b1) err_cnt++;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic mo);
        MOSI = b;
        tick(16);
        mo = MISO;
        SCLK = 1'b1;
        tick(16);
        SCLK = 1'b0;
    endtask

    // Drops SS_n, clocks nbits, leaves SS_n low after a final low phase.
    task automatic frame_body(input logic [15:0] w, input int nbits,
                              output logic [15:0] c);
        logic mo;
        c = '0;
        SS_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            send_bit((i < 16) ? w[15-i] : 1'b0, mo);
            c = {c[14:0], mo};
        end
        MOSI = 1'b0;
        tick(16);
    endtask

    initial begin
        tick(3);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_cmd_rdy", 32'(cmd_rdy), 32'h0);
        chk("rst_frm_err", 32'(frm_err), 32'h0);
        chk("rst_miso", 32'(MISO), 32'h0);
        rst_n = 1'b1;
        tick(8);

        // Basic frame and exact cmd_rdy latency
        frame_body(16'hA5C3, 16, cap);
        SS_n = 1'b1;
        tick(2);
        chk("rdy_edge2", 32'(cmd_rdy), 32'h0);
        tick(1);
        chk("rdy_edge3", 32'(cmd_rdy), 32'h1);
        chk("cmd_a5c3", 32'(cmd), 32'hA5C3);
        chk("miso_empty_buf", 32'(cap), 32'h0);
        tick(8);
        chk("no_err_f1", 32'(err_cnt), 32'h0);

        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        chk("clr_alone", 32'(cmd_rdy), 32'h0);

        // Response buffer loaded once, used by two frames
        tx_data = 16'h1234;
        wrt = 1'b1;
        tick(1);
        wrt = 1'b0;
        tx_data = 16'hFFFF;
        tick(4);
        frame_body(16'h5A5A, 16, cap);
        SS_n = 1'b1;
        tick(8);
        chk("miso_1234", 32'(cap), 32'h1234);
        chk("cmd_5a5a", 32'(cmd), 32'h5A5A);
        frame_body(16'h0F0F, 16, cap);
        SS_n = 1'b1;
        tick(8);
        chk("miso_persist", 32'(cap), 32'h1234);
        chk("cmd_0f0f", 32'(cmd), 32'h0F0F);
        chk("rdy_0f0f", 32'(cmd_rdy), 32'h1);

        // Short and long frames
        frame_body(16'hFFFF, 15, cap);
        SS_n = 1'b1;
        tick(3);
        chk("err15_pulse", 32'(frm_err), 32'h1);
        tick(1);
        chk("err15_end", 32'(frm_err), 32'h0);
        tick(4);
        chk("err15_cmd", 32'(cmd), 32'h0F0F);
        chk("err15_rdy", 32'(cmd_rdy), 32'h1);
        frame_body(16'hFFFF, 17, cap);
        SS_n = 1'b1;
        tick(3);
        chk("err17_pulse", 32'(frm_err), 32'h1);
        tick(5);
        chk("err_count", 32'(err_cnt), 32'h2);
        chk("err17_cmd", 32'(cmd), 32'h0F0F);

        // Set and clear in the same cycle
        frame_body(16'h3C96, 16, cap);
        SS_n = 1'b1;
        tick(2);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        chk("set_wins", 32'(cmd_rdy), 32'h1);
        chk("cmd_3c96", 32'(cmd), 32'h3C96);
        tick(1);
        clr_cmd_rdy = 1'b1;
        tick(1);
        clr_cmd_rdy = 1'b0;
        chk("clr_after", 32'(cmd_rdy), 32'h0);
        tick(6);

        // Reset in the middle of a frame
        SS_n = 1'b0;
        for (int i = 0; i < 8; i++) send_bit(1'b1, m);
        rst_n = 1'b0;
        tick(2);
        chk("midrst_cmd", 32'(cmd), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) send_bit(1'b1, m);
        tick(16);
        SS_n = 1'b1;
        tick(8);
        chk("midrst_rdy", 32'(cmd_rdy), 32'h0);
        chk("midrst_err", 32'(err_cnt), 32'h2);
        frame_body(16'h00FF, 16, cap);
        SS_n = 1'b1;
        tick(8);
        chk("cmd_00ff", 32'(cmd), 32'h00FF);
        chk("rdy_00ff", 32'(cmd_rdy), 32'h1);
        chk("miso_buf_rst", 32'(cap), 32'h0);

        // SCLK activity while deselected
        for (int i = 0; i < 5; i++) begin
            MOSI = ~MOSI;
            SCLK = 1'b1;
            tick(8);
            SCLK = 1'b0;
            tick(8);
        end
        chk("idle_cmd", 32'(cmd), 32'h00FF);
        chk("idle_rdy", 32'(cmd_rdy), 32'h1);
        chk("idle_miso", 32'(MISO), 32'h0);
        chk("idle_bitcnt", 32'(dut.bit_cnt_q), 32'd16);
        chk("idle_err", 32'(err_cnt), 32'h2);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
